// File: rtl/decode_stage_hz.sv
// rtl/decode_stage_hz.sv - RISC-V decode stage with register file, WB bypass and load-use stall
module decode_stage_hz #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32,
    parameter int REG_ADDR   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  i_if_valid,
    input  logic [31:0]           i_if_inst,
    input  logic [DATA_WIDTH-1:0] i_if_pc,
    input  logic                  i_flush,
    input  logic                  i_wb_reg_wr,
    input  logic [REG_ADDR-1:0]   i_wb_reg_destination,
    input  logic [DATA_WIDTH-1:0] i_wb_data,
    output logic                  o_id_stall,
    output logic                  o_id_valid,
    output logic                  o_id_reg_wr,
    output logic                  o_id_mem_rd,
    output logic                  o_id_mem_wr,
    output logic                  o_id_mem_to_reg,
    output logic                  o_id_alu_src1,
    output logic                  o_id_alu_src2,
    output logic                  o_id_branch,
    output logic                  o_id_jump,
    output logic                  o_id_illegal,
    output logic [1:0]            o_id_alu_op,
    output logic [DATA_WIDTH-1:0] o_id_pc,
    output logic [DATA_WIDTH-1:0] o_id_reg_read_data1,
    output logic [DATA_WIDTH-1:0] o_id_reg_read_data2,
    output logic [DATA_WIDTH-1:0] o_id_imm,
    output logic [REG_ADDR-1:0]   o_id_rs1,
    output logic [REG_ADDR-1:0]   o_id_rs2,
    output logic [REG_ADDR-1:0]   o_id_reg_destination,
    output logic [2:0]            o_id_funct3,
    output logic [6:0]            o_id_funct7
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;

    typedef struct packed {
        logic                  valid;
        logic                  reg_wr;
        logic                  mem_rd;
        logic                  mem_wr;
        logic                  mem_to_reg;
        logic                  alu_src1;
        logic                  alu_src2;
        logic                  branch;
        logic                  jump;
        logic                  illegal;
        logic [1:0]            alu_op;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] rdata1;
        logic [DATA_WIDTH-1:0] rdata2;
        logic [DATA_WIDTH-1:0] imm;
        logic [REG_ADDR-1:0]   rs1;
        logic [REG_ADDR-1:0]   rs2;
        logic [REG_ADDR-1:0]   rd;
        logic [2:0]            funct3;
        logic [6:0]            funct7;
    } idex_t;

    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
    logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
    idex_t                 idex_q, idex_d, dec;
    logic                  use_rs1, use_rs2, use_rd, known, wb_we;
    logic [4:0]            rs1_f, rs2_f, rd_f;
    logic [31:0]           imm32;

    assign rs1_f = i_if_inst[19:15];
    assign rs2_f = i_if_inst[24:20];
    assign rd_f  = i_if_inst[11:7];
    assign wb_we = clk_en && i_wb_reg_wr && (i_wb_reg_destination != '0)
                   && (int'(i_wb_reg_destination) < REG_COUNT);

    always_comb begin
        regs_d = regs_q;
        if (wb_we) regs_d[i_wb_reg_destination] = i_wb_data;
    end

    always_comb begin
        dec     = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        known   = 1'b1;
        imm32   = '0;
        case (i_if_inst[6:0])
            OP_LOAD: begin
                use_rs1 = 1'b1; use_rd = 1'b1;
                dec.reg_wr = 1'b1; dec.mem_rd = 1'b1; dec.mem_to_reg = 1'b1; dec.alu_src2 = 1'b1;
                imm32 = {{20{i_if_inst[31]}}, i_if_inst[31:20]};
            end
            OP_STORE: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec.mem_wr = 1'b1; dec.alu_src2 = 1'b1;
                imm32 = {{20{i_if_inst[31]}}, i_if_inst[31:25], i_if_inst[11:7]};
            end
            OP_BRANCH: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec.branch = 1'b1; dec.alu_op = 2'b01;
                imm32 = {{20{i_if_inst[31]}}, i_if_inst[7], i_if_inst[30:25], i_if_inst[11:8], 1'b0};
            end
            OP_JAL: begin
                use_rd = 1'b1;
                dec.jump = 1'b1; dec.reg_wr = 1'b1; dec.alu_src1 = 1'b1;
                imm32 = {{12{i_if_inst[31]}}, i_if_inst[19:12], i_if_inst[20], i_if_inst[30:21], 1'b0};
            end
            OP_JALR: begin
                use_rs1 = 1'b1; use_rd = 1'b1;
                dec.jump = 1'b1; dec.reg_wr = 1'b1; dec.alu_src2 = 1'b1;
                imm32 = {{20{i_if_inst[31]}}, i_if_inst[31:20]};
            end
            OP_AUIPC: begin
                use_rd = 1'b1;
                dec.alu_src1 = 1'b1; dec.alu_src2 = 1'b1; dec.reg_wr = 1'b1;
                imm32 = {i_if_inst[31:12], 12'b0};
            end
            OP_LUI: begin
                use_rd = 1'b1;
                dec.alu_src2 = 1'b1; dec.reg_wr = 1'b1;
                imm32 = {i_if_inst[31:12], 12'b0};
            end
            OP_R: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
                dec.alu_op = 2'b10; dec.reg_wr = 1'b1;
            end
            OP_I: begin
                use_rs1 = 1'b1; use_rd = 1'b1;
                dec.alu_op = 2'b11; dec.alu_src2 = 1'b1; dec.reg_wr = 1'b1;
                imm32 = {{20{i_if_inst[31]}}, i_if_inst[31:20]};
            end
            default: known = 1'b0;
        endcase

        dec.valid  = 1'b1;
        dec.pc     = i_if_pc;
        dec.imm    = DATA_WIDTH'($signed(imm32));
        dec.funct3 = i_if_inst[14:12];
        dec.funct7 = i_if_inst[31:25];
        dec.rs1    = use_rs1 ? REG_ADDR'(rs1_f) : '0;
        dec.rs2    = use_rs2 ? REG_ADDR'(rs2_f) : '0;
        dec.rd     = use_rd  ? REG_ADDR'(rd_f)  : '0;

        // Same-cycle writeback wins over the stored value
        if (use_rs1 && rs1_f != 5'd0 && int'(rs1_f) < REG_COUNT)
            dec.rdata1 = (wb_we && int'(i_wb_reg_destination) == int'(rs1_f)) ? i_wb_data : regs_q[rs1_f];
        if (use_rs2 && rs2_f != 5'd0 && int'(rs2_f) < REG_COUNT)
            dec.rdata2 = (wb_we && int'(i_wb_reg_destination) == int'(rs2_f)) ? i_wb_data : regs_q[rs2_f];

        if (!known || (use_rs1 && int'(rs1_f) >= REG_COUNT) || (use_rs2 && int'(rs2_f) >= REG_COUNT)
                   || (use_rd && int'(rd_f) >= REG_COUNT)) begin
            dec.reg_wr = 1'b0; dec.mem_rd = 1'b0; dec.mem_wr = 1'b0; dec.mem_to_reg = 1'b0;
            dec.alu_src1 = 1'b0; dec.alu_src2 = 1'b0; dec.branch = 1'b0; dec.jump = 1'b0;
            dec.alu_op = 2'b00; dec.illegal = 1'b1;
        end
    end

    always_comb begin
        o_id_stall = !rst && !i_flush && i_if_valid && idex_q.valid && idex_q.mem_rd
                     && (idex_q.rd != '0)
                     && ((use_rs1 && int'(idex_q.rd) == int'(rs1_f))
                      || (use_rs2 && int'(idex_q.rd) == int'(rs2_f)));
    end

    always_comb begin
        idex_d = idex_q;
        if (clk_en) begin
            if (i_flush || o_id_stall || !i_if_valid) idex_d = '0;
            else                                      idex_d = dec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q <= '0;
            for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
        end else begin
            idex_q <= idex_d;
            regs_q <= regs_d;
        end
    end

    assign o_id_valid           = idex_q.valid;
    assign o_id_reg_wr          = idex_q.reg_wr;
    assign o_id_mem_rd          = idex_q.mem_rd;
    assign o_id_mem_wr          = idex_q.mem_wr;
    assign o_id_mem_to_reg      = idex_q.mem_to_reg;
    assign o_id_alu_src1        = idex_q.alu_src1;
    assign o_id_alu_src2        = idex_q.alu_src2;
    assign o_id_branch          = idex_q.branch;
    assign o_id_jump            = idex_q.jump;
    assign o_id_illegal         = idex_q.illegal;
    assign o_id_alu_op          = idex_q.alu_op;
    assign o_id_pc              = idex_q.pc;
    assign o_id_reg_read_data1  = idex_q.rdata1;
    assign o_id_reg_read_data2  = idex_q.rdata2;
    assign o_id_imm             = idex_q.imm;
    assign o_id_rs1             = idex_q.rs1;
    assign o_id_rs2             = idex_q.rs2;
    assign o_id_reg_destination = idex_q.rd;
    assign o_id_funct3          = idex_q.funct3;
    assign o_id_funct7          = idex_q.funct7;

endmodule

// File: doc/decode_stage_hz.md
DECODE_STAGE_HZ -- requirements
Module: decode_stage_hz

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath width (32 or 64).
REQ-002 SHALL have parameter REG_COUNT, default 32, architectural registers (16 = RV32E mode, or 32).
REQ-003 SHALL have parameter REG_ADDR, default 5, register index width; index fields remain 5 bits in the instruction.
REQ-004 Ports, in this order:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- clk_en  in  1  stage enable.
- i_if_valid  in  1  instruction present.
- i_if_inst  in  32  instruction.
- i_if_pc  in  DATA_WIDTH  instruction PC.
- i_flush  in  1  kill the instruction in decode.
- i_wb_reg_wr  in  1  register write enable from writeback.
- i_wb_reg_destination  in  REG_ADDR  writeback register index.
- i_wb_data  in  DATA_WIDTH  writeback data.
- o_id_stall  out  1  combinational; IF holds PC/instruction.
- o_id_valid  out  1  ID/EX register holds a real instruction.
- o_id_reg_wr, o_id_mem_rd, o_id_mem_wr, o_id_mem_to_reg, o_id_alu_src1, o_id_alu_src2, o_id_branch, o_id_jump, o_id_illegal  out  1 each  registered controls.
- o_id_alu_op  out  2  00 add, 01 branch compare, 10 R-type, 11 I-type ALU.
- o_id_pc, o_id_reg_read_data1, o_id_reg_read_data2, o_id_imm  out  DATA_WIDTH  registered.
- o_id_rs1, o_id_rs2, o_id_reg_destination  out  REG_ADDR  registered.
- o_id_funct3  out  3;  o_id_funct7  out  7  registered.

Function
REQ-005 Register file: REG_COUNT x DATA_WIDTH; x0 reads 0, writes to x0 ignored.
REQ-006 Write on rising clk when clk_en & i_wb_reg_wr & destination != 0.
REQ-007 Read bypass: a read of the register being written in the same cycle returns i_wb_data, not the old value.
REQ-008 Decode latency is one cycle: the instruction sampled at edge N appears on o_id_* after edge N.
REQ-009 Immediates are sign-extended to DATA_WIDTH for I, S, B (bit0 = 0), U (low 12 bits = 0) and J (bit0 = 0) formats; R-type imm = 0.
REQ-010 Operand use:
- rs1 used by R, I-ALU, LOAD, STORE, BRANCH, JALR.
- rs2 used by R, STORE, BRANCH.
- Unused rs fields are forced to index 0 and their data to 0.
REQ-011 Control settings:
- LOAD: reg_wr, mem_rd, mem_to_reg, alu_src2.
- STORE: mem_wr, alu_src2.
- BRANCH: branch, alu_op 01.
- JAL: jump, reg_wr, alu_src1.
- JALR: jump, reg_wr, alu_src2.
- AUIPC: alu_src1, alu_src2, reg_wr.
- LUI: alu_src2, reg_wr.
- R: alu_op 10, reg_wr.
- I-ALU: alu_op 11, alu_src2, reg_wr.
REQ-012 Illegal: unknown opcode, or any used rs/rd index >= REG_COUNT.
- o_id_illegal = 1 and o_id_valid = 1.
- All other control outputs are 0.
REQ-013 Load-use hazard: o_id_stall = 1 when all of the following hold:
- o_id_valid & o_id_mem_rd;
- o_id_reg_destination != 0;
- i_if_valid;
- o_id_reg_destination equals a used rs index of i_if_inst.
REQ-014 On stall, the ID/EX register loads a bubble (valid and all controls 0); the held instruction decodes on the next edge and stall drops.
REQ-015 A stall lasts exactly one cycle per load-use pair.
REQ-016 i_flush has priority over stall:
- the ID/EX register loads a bubble;
- o_id_stall = 0 while i_flush = 1.
REQ-017 i_if_valid = 0 loads a bubble.
REQ-018 clk_en = 0 freezes all state, including the register file.
- o_id_stall is still computed from the held state.

Reset
REQ-019 While rst = 1 at an edge, the following clear to 0, regardless of clk_en: every o_id_* output, o_id_valid, and all registers.
REQ-020 o_id_stall = 0 during reset.
REQ-021 Reset mid-stall discards the held instruction; decode resumes from the inputs on the first edge after rst falls.

Verification
REQ-022 WB writes x1 = 10, x2 = 20, then ADD x5,x1,x2 -> one cycle later read_data1 = 10, read_data2 = 20, alu_op 10, reg_wr 1, rd 5.
REQ-023 WB writes x3 = 0x33 in the same cycle ADDI x6,x3,-1 is decoded -> read_data1 = 0x33, imm = all ones.
REQ-024 LW x7,0(x2) then ADD x8,x7,x1 -> o_id_stall = 1 for one cycle, one bubble (valid 0), then the ADD issues with rs1 = 7.
REQ-025 LW x7 then ADDI x8,x0,1 -> no stall; LW x0 then use of x0 -> no stall.
REQ-026 REG_COUNT = 16: ADD x20,x1,x2 -> illegal 1, reg_wr 0, valid 1; a flush during a load-use stall -> bubble, stall 0.
REQ-027 Assert rst during a stall -> all outputs 0 next cycle; x1 reads 0 afterwards.
